// File: rtl/vec_mul_lane_pipe.sv
`default_nettype none
// ============================================================================
// Module  : vec_mul_lane_pipe
// Brief   : Two-stage SIMD integer multiplier (4x8 / 2x16 / 1x32 lanes) with
//           valid/ready handshake on both sides.
// Revision: 1.0 - initial release
// ============================================================================
module vec_mul_lane_pipe #(
    parameter int REG_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           sew,
    input  logic [1:0]           mul_op,
    input  logic [REG_WIDTH-1:0] data_A,
    input  logic [REG_WIDTH-1:0] data_B,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [REG_WIDTH-1:0] result,
    output logic                 sew_err
);

    localparam logic [1:0] c_SEW8      = 2'b00;
    localparam logic [1:0] c_SEW16     = 2'b01;
    localparam logic [1:0] c_SEW32     = 2'b10;
    localparam logic [1:0] c_OP_MUL    = 2'b00;
    localparam logic [1:0] c_OP_MULH   = 2'b01;
    localparam logic [1:0] c_OP_MULHSU = 2'b11;
    localparam int         c_LANES8    = REG_WIDTH / 8;
    localparam int         c_LANES16   = REG_WIDTH / 16;

    logic w_adv1;
    logic w_adv2;
    logic w_a_sign;
    logic w_b_sign;

    logic        r_s1_valid;
    logic [1:0]  r_s1_sew;
    logic [1:0]  r_s1_op;
    logic [15:0] r_p8  [c_LANES8];
    logic [31:0] r_p16 [c_LANES16];
    logic [2*REG_WIDTH-1:0] r_p32;

    logic                 r_s2_valid;
    logic [REG_WIDTH-1:0] r_result;
    logic                 r_sew_err;

    logic [15:0]            w_p8  [c_LANES8];
    logic [31:0]            w_p16 [c_LANES16];
    logic [2*REG_WIDTH-1:0] w_p32;
    logic [REG_WIDTH-1:0]   w_sel;

    assign w_adv2   = !r_s2_valid || out_ready;
    assign w_adv1   = !r_s1_valid || w_adv2;
    assign in_ready = w_adv1;

    assign w_a_sign = (mul_op == c_OP_MULH) || (mul_op == c_OP_MULHSU);
    assign w_b_sign = (mul_op == c_OP_MULH);

    // Each lane is extended by one bit so signed and unsigned forms share one
    // signed multiplier; only the low 2*SEW bits of the product are kept.
    for (genvar i = 0; i < c_LANES8; i++) begin : g_lane8
        logic signed [8:0] w_a;
        logic signed [8:0] w_b;
        assign w_a     = {w_a_sign & data_A[8*i+7], data_A[8*i +: 8]};
        assign w_b     = {w_b_sign & data_B[8*i+7], data_B[8*i +: 8]};
        assign w_p8[i] = 16'(w_a) * 16'(w_b);
    end

    for (genvar i = 0; i < c_LANES16; i++) begin : g_lane16
        logic signed [16:0] w_a;
        logic signed [16:0] w_b;
        assign w_a      = {w_a_sign & data_A[16*i+15], data_A[16*i +: 16]};
        assign w_b      = {w_b_sign & data_B[16*i+15], data_B[16*i +: 16]};
        assign w_p16[i] = 32'(w_a) * 32'(w_b);
    end

    if (1) begin : g_lane32
        logic signed [REG_WIDTH:0] w_a;
        logic signed [REG_WIDTH:0] w_b;
        assign w_a   = {w_a_sign & data_A[REG_WIDTH-1], data_A};
        assign w_b   = {w_b_sign & data_B[REG_WIDTH-1], data_B};
        assign w_p32 = (2*REG_WIDTH)'(w_a) * (2*REG_WIDTH)'(w_b);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_valid <= 1'b0;
            r_s1_sew   <= 2'b00;
            r_s1_op    <= 2'b00;
            r_p32      <= '0;
            for (int i = 0; i < c_LANES8; i++)  r_p8[i]  <= '0;
            for (int i = 0; i < c_LANES16; i++) r_p16[i] <= '0;
        end else if (w_adv1) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_sew <= sew;
                r_s1_op  <= mul_op;
                r_p32    <= w_p32;
                for (int i = 0; i < c_LANES8; i++)  r_p8[i]  <= w_p8[i];
                for (int i = 0; i < c_LANES16; i++) r_p16[i] <= w_p16[i];
            end
        end
    end

    always_comb begin
        w_sel = '0;
        case (r_s1_sew)
            c_SEW8: begin
                for (int i = 0; i < c_LANES8; i++)
                    w_sel[8*i +: 8] = (r_s1_op == c_OP_MUL) ? r_p8[i][7:0] : r_p8[i][15:8];
            end
            c_SEW16: begin
                for (int i = 0; i < c_LANES16; i++)
                    w_sel[16*i +: 16] = (r_s1_op == c_OP_MUL) ? r_p16[i][15:0] : r_p16[i][31:16];
            end
            c_SEW32: begin
                w_sel = (r_s1_op == c_OP_MUL) ? r_p32[REG_WIDTH-1:0]
                                              : r_p32[2*REG_WIDTH-1:REG_WIDTH];
            end
            default: w_sel = '0;
        endcase
    end

    // Result only moves on adv2, which holds it stable under backpressure.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s2_valid <= 1'b0;
            r_result   <= '0;
            r_sew_err  <= 1'b0;
        end else if (w_adv2) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_result  <= w_sel;
                r_sew_err <= (r_s1_sew == 2'b11);
            end
        end
    end

    assign out_valid = r_s2_valid;
    assign result    = r_result;
    assign sew_err   = r_sew_err;

endmodule
`default_nettype wire

// File: tb/tb_vec_mul_lane_pipe.sv
`default_nettype none
// ============================================================================
// Module  : tb_vec_mul_lane_pipe
// Brief   : Scoreboard bench for vec_mul_lane_pipe.
// Revision: 1.0 - initial release
// ============================================================================
module tb_vec_mul_lane_pipe;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  sew;
    logic [1:0]  mul_op;
    logic [31:0] data_A;
    logic [31:0] data_B;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        sew_err;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_out   = 0;
    int          n_full  = 0;
    int          n_hold  = 0;
    logic [32:0] q_exp[$];
    logic        r_stall_prev = 1'b0;
    logic [32:0] r_held;
    logic        stream_done;

    vec_mul_lane_pipe #(.REG_WIDTH(32)) u_dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sew       (sew),
        .mul_op    (mul_op),
        .data_A    (data_A),
        .data_B    (data_B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .sew_err   (sew_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: each lane in 128-bit two's complement, {sew_err, result}.
    function automatic logic [32:0] model(input logic [1:0] s, input logic [1:0] op,
                                          input logic [31:0] a, input logic [31:0] b);
        logic [31:0]  r;
        logic [127:0] la, lb, p, mask;
        int           w, n;
        if (s == 2'b11) return {1'b1, 32'h0};
        w    = 8 << s;
        n    = 4 >> s;
        mask = (128'd1 << w) - 128'd1;
        r    = '0;
        for (int i = 0; i < n; i++) begin
            la = {96'd0, a >> (i*w)} & mask;
            lb = {96'd0, b >> (i*w)} & mask;
            if ((op == 2'b01 || op == 2'b11) && la[w-1]) la = la - (128'd1 << w);
            if (op == 2'b01 && lb[w-1])                   lb = lb - (128'd1 << w);
            p = la * lb;
            if (op != 2'b00) p = p >> w;
            r = r | 32'((p & mask) << (i*w));
        end
        return {1'b0, r};
    endfunction

    always @(negedge clk) begin
        if (reset_n) begin
            if (in_valid && in_ready) q_exp.push_back(model(sew, mul_op, data_A, data_B));
            if (!in_ready) n_full++;
            if (r_stall_prev && out_valid) begin
                n_hold++;
                check("stall_hold", {31'd0, sew_err, result}, {31'd0, r_held});
            end
            if (out_valid && out_ready) begin
                n_out++;
                if (q_exp.size() == 0) check("unexpected_out", 64'd1, 64'd0);
                else check("result", {31'd0, sew_err, result}, {31'd0, q_exp.pop_front()});
            end
            r_stall_prev = out_valid && !out_ready;
            r_held       = {sew_err, result};
        end else begin
            r_stall_prev = 1'b0;
        end
    end

    task automatic send(input logic [1:0] s, input logic [1:0] op,
                        input logic [31:0] a, input logic [31:0] b);
        bit done = 0;
        int cyc  = 0;
        in_valid = 1'b1; sew = s; mul_op = op; data_A = a; data_B = b;
        while (!done) begin
            @(negedge clk);
            done = in_ready;
            @(posedge clk);
            #1;
            if (!done && ++cyc > 50) begin
                check("send_timeout", 64'd0, 64'd1);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic send_lat(input string tag, input logic [1:0] s, input logic [1:0] op,
                            input logic [31:0] a, input logic [31:0] b, input logic [32:0] exp);
        in_valid = 1'b1; sew = s; mul_op = op; data_A = a; data_B = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check({tag, "_valid_c1"}, {63'd0, out_valid}, 64'd0);
        @(posedge clk);
        #1;
        check({tag, "_valid_c2"}, {63'd0, out_valid}, 64'd1);
        check(tag, {31'd0, sew_err, result}, {31'd0, exp});
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input string tag);
        int cyc = 0;
        while (q_exp.size() != 0 && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check({tag, "_drained"}, 64'(q_exp.size()), 64'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int out0;
        reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        sew = '0; mul_op = '0; data_A = '0; data_B = '0;
        #12;
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_result", {32'd0, result}, 64'd0);
        check("rst_sew_err", {63'd0, sew_err}, 64'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        #1;
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        #1;

        send_lat("sew8_mul",    2'b00, 2'b00, 32'h02FF7F80, 32'h03020202, {1'b0, 32'h06FEFE00});
        send_lat("sew8_mulh",   2'b00, 2'b01, 32'h02FF7F80, 32'h03020202, {1'b0, 32'h00FF00FF});
        send_lat("sew8_mulhu",  2'b00, 2'b10, 32'h02FF7F80, 32'h03020202, {1'b0, 32'h00010001});
        send_lat("sew32_mulhu", 2'b10, 2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, {1'b0, 32'hFFFFFFFE});
        send_lat("sew32_mul",   2'b10, 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, {1'b0, 32'h00000001});
        send_lat("sew32_mulh",  2'b10, 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, {1'b0, 32'h00000000});
        send_lat("sew16_mulhsu",2'b01, 2'b11, 32'h0003FFFF, 32'h0002FFFF, {1'b0, 32'h0000FFFF});
        send_lat("sew_illegal", 2'b11, 2'b01, 32'h12345678, 32'h9ABCDEF0, {1'b1, 32'h00000000});
        wait_drain("directed");

        // Five back-to-back ops with out_ready low for cycles 3-5.
        out0 = n_out; n_full = 0; n_hold = 0;
        fork
            begin
                for (int i = 0; i < 5; i++)
                    send(2'(i % 3), 2'(i), 32'h81F0_7F10 + 32'(i) * 32'h0101_0203, 32'hC3A5_5A3C ^ 32'(i*7));
            end
            begin
                repeat (2) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        wait_drain("bp");
        check("bp_count", 64'(n_out - out0), 64'd5);
        check("bp_in_ready_low", 64'(n_full > 0), 64'd1);
        check("bp_hold_seen", 64'(n_hold > 0), 64'd1);

        // Random stream with random backpressure and occasional illegal sew.
        out0 = n_out; stream_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 40; i++)
                    send(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), $urandom, $urandom);
                stream_done = 1'b1;
            end
            begin
                while (!stream_done) begin
                    @(posedge clk);
                    #1 out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        wait_drain("rand");
        check("rand_count", 64'(n_out - out0), 64'd40);

        // Reset with two ops in flight: no output then or afterwards.
        out_ready = 1'b0;
        send(2'b00, 2'b00, 32'h11223344, 32'h55667788);
        send(2'b01, 2'b10, 32'hAABBCCDD, 32'h01020304);
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
        q_exp.delete();
        @(posedge clk);
        #1 reset_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check("post_rst_out_valid", {63'd0, out_valid}, 64'd0);
        end
        send_lat("post_rst_op", 2'b01, 2'b00, 32'h00050003, 32'h00070009, {1'b0, 32'h0023001B});
        wait_drain("final");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
